// File: rtl/fetch_queue_unit.sv
// RV32 fetch stage: sequential fetch address generation, credit-limited imem requests,
// an in-order response queue feeding decode, and internal branch/JALR redirect handling.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [XLEN-1:0]               imem_rsp_data,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [XLEN-1:0]               id_inst,
  output logic [XLEN-1:0]               id_pc,
  input  logic                          redirect_valid,
  input  logic                          redirect_isjalr,
  input  logic [XLEN-1:0]               redirect_base_pc,
  input  logic [XLEN-1:0]               redirect_offset,
  input  logic [XLEN-1:0]               redirect_jalr_reg,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);

  logic            en_q;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] q_inst [FQ_DEPTH];
  logic [XLEN-1:0] q_pc   [FQ_DEPTH];

  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;
  logic            credit;
  logic            req_fire;
  logic            push;
  logic            pop;

  assign target_sum = (redirect_isjalr ? redirect_jalr_reg : redirect_base_pc) + redirect_offset;
  assign target     = {target_sum[XLEN-1:2], 2'b00};

  // In-flight requests plus queued entries never exceed the queue size, so every response has a slot.
  assign credit         = ({1'b0, outstanding} + {1'b0, fq_count}) < (CW+1)'(FQ_DEPTH);
  assign imem_req_valid = en_q & ~redirect_valid & credit;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign id_valid = (fq_count != '0) & ~redirect_valid;
  assign id_inst  = q_inst[rd_ptr];
  assign id_pc    = q_pc[rd_ptr];
  assign pop      = id_valid & id_ready;
  assign push     = imem_rsp_valid & ~redirect_valid & (discard == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fq_count    <= '0;
    end else begin
      en_q <= 1'b1;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path; a response this cycle is already dropped.
        fetch_pc    <= target;
        rsp_pc      <= target;
        outstanding <= outstanding - CW'(imem_rsp_valid);
        discard     <= outstanding - CW'(imem_rsp_valid);
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        fq_count    <= '0;
      end else begin
        outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (imem_rsp_valid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          q_inst[wr_ptr] <= imem_rsp_data;
          q_pc[wr_ptr]   <= rsp_pc;
          wr_ptr         <= wr_ptr + PW'(1);
          rsp_pc         <= rsp_pc + XLEN'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        fq_count <= fq_count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
